// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO write-port arbiter.
// Parameter legality and pointer wrap live here so every unit agrees.
package fifo_arb_pkg;

  function automatic int depth_of(int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic int unsigned wrap_inc(int unsigned v,
                                           int unsigned depth);
    return (v + 32'd1 >= depth) ? 32'd0 : v + 32'd1;
  endfunction

  function automatic bit params_ok(int addr_w, int depth, int nreq);
    return (depth == depth_of(addr_w)) && (nreq >= 2) && (nreq <= 8);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot picker with a registered last-winner pointer.
// Search starts one past the last winner and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] pick
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;
  logic [IW-1:0] k;
  logic          found;
  int            idx;

  always_comb begin
    pick   = '0;
    last_d = last_q;
    found  = 1'b0;
    idx    = 0;
    k      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_q) + i) % NUM_REQ;
      k   = IW'(idx);
      if (en && !found && req[k]) begin
        found   = 1'b1;
        pick[k] = 1'b1;
        last_d  = k;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= IW'(NUM_REQ - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one memory write port among NUM_REQ producers and owns
// the FIFO pointers; issued counts grants, committed counts writes.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ADDRESS = 3,
  parameter int DEPTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                     W_CLK,
  input  logic                     W_RST,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [NUM_REQ*WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]       GNT,
  output logic [WIDTH-1:0]         W_DATA,
  output logic                     W_INC,
  output logic [ADDRESS-1:0]       W_ADDR,
  output logic [ADDRESS-1:0]       R_ADDR,
  input  logic                     R_INC,
  output logic                     FULL,
  output logic                     R_EMPTY,
  output logic [ADDRESS:0]         COUNT
);

  localparam int CW = ADDRESS + 1;

  if (!params_ok(ADDRESS, DEPTH, NUM_REQ)) begin : g_bad_params
    $error("fifo_wr_arbiter: illegal ADDRESS/DEPTH/NUM_REQ");
  end

  logic [ADDRESS-1:0] wptr_q, wptr_d;
  logic [ADDRESS-1:0] rptr_q, rptr_d;
  logic [CW-1:0]      issued_q, issued_d;
  logic [CW-1:0]      committed_q, committed_d;
  logic               stg_valid_q, stg_valid_d;
  logic [WIDTH-1:0]   stg_data_q, stg_data_d;
  logic [ADDRESS-1:0] stg_addr_q, stg_addr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;

  logic [NUM_REQ-1:0] pick;
  logic [WIDTH-1:0]   sel_data;
  logic               full;
  logic               pop;
  logic               grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk  (W_CLK),
    .rst  (W_RST),
    .req  (REQ),
    .en   (!full),
    .pick (pick)
  );

  always_comb begin
    full     = (issued_q == CW'(DEPTH));
    pop      = R_INC && (committed_q != '0);
    grant    = |pick;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick[k]) sel_data = REQ_DATA[k*WIDTH +: WIDTH];
    end
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    stg_data_d  = stg_data_q;
    stg_addr_d  = stg_addr_q;
    stg_valid_d = grant;
    gnt_d       = pick;
    if (grant) begin
      wptr_d     = ADDRESS'(wrap_inc(32'(wptr_q), DEPTH));
      stg_data_d = sel_data;
      stg_addr_d = wptr_q;
    end
    if (pop) rptr_d = ADDRESS'(wrap_inc(32'(rptr_q), DEPTH));
    // a grant and a pop at one edge cancel in issued
    issued_d    = issued_q + CW'(grant) - CW'(pop);
    committed_d = committed_q + CW'(stg_valid_q) - CW'(pop);
  end

  always_ff @(posedge W_CLK) begin
    if (W_RST) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      issued_q    <= '0;
      committed_q <= '0;
      stg_valid_q <= 1'b0;
      stg_data_q  <= '0;
      stg_addr_q  <= '0;
      gnt_q       <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      issued_q    <= issued_d;
      committed_q <= committed_d;
      stg_valid_q <= stg_valid_d;
      stg_data_q  <= stg_data_d;
      stg_addr_q  <= stg_addr_d;
      gnt_q       <= gnt_d;
    end
  end

  assign GNT     = gnt_q;
  assign W_INC   = stg_valid_q;
  assign W_DATA  = stg_data_q;
  assign W_ADDR  = stg_addr_q;
  assign R_ADDR  = rptr_q;
  assign FULL    = full;
  assign R_EMPTY = (committed_q == '0);
  assign COUNT   = committed_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-based FIFO model plus a
// behavioural memory; directed scenarios then random traffic.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 8;

  logic           W_CLK = 1'b0;
  logic           W_RST = 1'b1;
  logic [N-1:0]   REQ;
  logic [N*W-1:0] REQ_DATA;
  logic [N-1:0]   GNT;
  logic [W-1:0]   W_DATA;
  logic           W_INC;
  logic [2:0]     W_ADDR;
  logic [2:0]     R_ADDR;
  logic           R_INC = 1'b0;
  logic           FULL;
  logic           R_EMPTY;
  logic [3:0]     COUNT;
  logic [W-1:0]   R_DATA;

  logic [W-1:0]   dat [N];
  logic [W-1:0]   mem [D];

  int total = 0;
  int bad   = 0;

  // reference model state
  int           last_m;
  int           wptr_m;
  int           rptr_m;
  int           issued_m;
  bit           pend_v;
  logic [W-1:0] pend_d;
  int           pend_a;
  logic [N-1:0] gnt_m;
  logic [W-1:0] q [$];

  fifo_wr_arbiter #(
    .WIDTH(W), .ADDRESS(3), .DEPTH(D), .NUM_REQ(N)
  ) dut (
    .W_CLK(W_CLK), .W_RST(W_RST), .REQ(REQ), .REQ_DATA(REQ_DATA),
    .GNT(GNT), .W_DATA(W_DATA), .W_INC(W_INC), .W_ADDR(W_ADDR),
    .R_ADDR(R_ADDR), .R_INC(R_INC), .FULL(FULL), .R_EMPTY(R_EMPTY),
    .COUNT(COUNT)
  );

  always #5 W_CLK = ~W_CLK;

  always_comb REQ_DATA = {dat[3], dat[2], dat[1], dat[0]};

  always @(posedge W_CLK) if (W_INC) mem[W_ADDR] <= W_DATA;
  assign R_DATA = mem[R_ADDR];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    last_m = N - 1; wptr_m = 0; rptr_m = 0; issued_m = 0;
    pend_v = 0; pend_d = '0; pend_a = 0; gnt_m = '0;
    q.delete();
  endtask

  // advance model and DUT one edge, then compare every output
  task automatic step();
    int  pick;
    bit  pop;
    pick = -1;
    pop  = R_INC && (q.size() > 0);
    if (pop && !W_RST) chk("rdata", 32'(R_DATA), 32'(q[0]));
    if (REQ != '0 && issued_m < D) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (last_m + i) % N;
        if (pick < 0 && REQ[k]) pick = k;
      end
    end
    if (W_RST) begin
      model_reset();
    end else begin
      if (pend_v) q.push_back(pend_d);
      if (pop) begin
        void'(q.pop_front());
        rptr_m = (rptr_m + 1) % D;
        issued_m--;
      end
      if (pick >= 0) begin
        pend_v = 1; pend_d = dat[pick]; pend_a = wptr_m;
        wptr_m = (wptr_m + 1) % D;
        issued_m++;
        last_m = pick;
        gnt_m  = N'(1 << pick);
      end else begin
        pend_v = 0;
        gnt_m  = '0;
      end
    end
    @(posedge W_CLK);
    #1;
    chk("gnt", 32'(GNT), 32'(gnt_m));
    chk("w_inc", 32'(W_INC), 32'(pend_v));
    if (pend_v) begin
      chk("w_addr", 32'(W_ADDR), 32'(pend_a));
      chk("w_data", 32'(W_DATA), 32'(pend_d));
    end
    chk("count", 32'(COUNT), 32'(q.size()));
    chk("full", 32'(FULL), 32'(issued_m == D));
    chk("empty", 32'(R_EMPTY), 32'(q.size() == 0));
    chk("r_addr", 32'(R_ADDR), 32'(rptr_m));
  endtask

  task automatic do_reset();
    W_RST = 1; REQ = '0; R_INC = 0;
    step();
    W_RST = 0;
  endtask

  task automatic drain();
    REQ = '0;
    for (int i = 0; i < 12; i++) begin
      R_INC = 1;
      step();
    end
    R_INC = 0;
  endtask

  initial begin
    logic [N-1:0] rr_exp [5];
    REQ = '0;
    for (int k = 0; k < N; k++) dat[k] = '0;
    model_reset();

    // reset state
    do_reset();
    chk("rst_wdata", 32'(W_DATA), 32'h0);
    chk("rst_waddr", 32'(W_ADDR), 32'h0);

    // single producer
    REQ = 4'b0001; dat[0] = 8'hA5;
    step();
    chk("single_gnt", 32'(GNT), 32'h1);
    chk("single_wdata", 32'(W_DATA), 32'hA5);
    REQ = '0;
    step();
    chk("single_rdata", 32'(R_DATA), 32'hA5);
    chk("single_count", 32'(COUNT), 32'h1);

    // round robin with all four requesting
    do_reset();
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    for (int k = 0; k < N; k++) dat[k] = 8'(8'h10 + k);
    REQ = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_gnt", 32'(GNT), 32'(rr_exp[i]));
      chk("rr_waddr", 32'(W_ADDR), 32'(i));
    end
    drain();

    // full, then one pop frees a slot at wrapped address 0
    do_reset();
    REQ = 4'b1111;
    for (int i = 0; i < 8; i++) step();
    chk("full_set", 32'(FULL), 32'h1);
    step();
    chk("full_nognt", 32'(GNT), 32'h0);
    R_INC = 1;
    step();
    R_INC = 0;
    chk("full_clr", 32'(FULL), 32'h0);
    step();
    chk("wrap_gnt", 32'(GNT != '0), 32'h1);
    chk("wrap_addr", 32'(W_ADDR), 32'h0);
    REQ = '0;
    drain();

    // ignored pop on empty, then grant + pop at COUNT=3
    do_reset();
    R_INC = 1;
    step();
    R_INC = 0;
    chk("epop_count", 32'(COUNT), 32'h0);
    chk("epop_raddr", 32'(R_ADDR), 32'h0);
    REQ = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      dat[0] = 8'(8'h30 + i);
      step();
    end
    REQ = '0;
    step();
    chk("cnt3", 32'(COUNT), 32'h3);
    REQ = 4'b0010; dat[1] = 8'h77; R_INC = 1;
    step();
    REQ = '0; R_INC = 0;
    step();
    chk("gnt_pop_cnt", 32'(COUNT), 32'h3);
    drain();

    // reset while a write is in flight
    do_reset();
    REQ = 4'b0100; dat[2] = 8'h5C;
    step();
    chk("mid_winc_pre", 32'(W_INC), 32'h1);
    W_RST = 1; REQ = '0;
    step();
    W_RST = 0;
    chk("mid_winc", 32'(W_INC), 32'h0);
    chk("mid_count", 32'(COUNT), 32'h0);
    chk("mid_empty", 32'(R_EMPTY), 32'h1);
    REQ = 4'b1111;
    step();
    chk("mid_first", 32'(GNT), 32'h1);
    REQ = '0;
    drain();

    // random traffic with wrap-around
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (GNT[k]) begin
          if ($urandom_range(1) == 0) REQ[k] = 1'b0;
          else dat[k] = 8'($urandom);
        end
        if (!REQ[k] && $urandom_range(2) == 0) begin
          REQ[k] = 1'b1;
          dat[k] = 8'($urandom);
        end
      end
      R_INC = ($urandom_range(2) != 0);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
